id_stage_fwd: RTL and testbench
===============================

# id_stage_fwd

Parametrised instruction-decode stage with registered ID/EX output, N-source operand forwarding and load-use interlock. Sits between the IF/ID register and EX: reads the register file combinationally, resolves RAW hazards against `NUM_FWD` younger pipeline stages, and presents a decoded micro-op to EX through a valid/ready handshake. It stalls upstream when a needed operand is still in flight from a load, and accepts a flush.

## Interface
- `DATA_W`, 32: datapath width; legal values are 32 and 64.
- `REG_AW`, 5: register address width.
- `NUM_FWD`, 2: number of forwarding sources; index 0 is the youngest (EX).
- `STALL_CNT_W`, 16: width of the stall statistics counter.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `pc_i`/`inst_i` carry a valid instruction.
- `in_ready` out 1: instruction accepted on this edge when `in_valid` is also high.
- `pc_i` in 32: instruction address.
- `inst_i` in 32: instruction word.
- `reg1_read_o`, `reg2_read_o` out 1: regfile read enables (combinational).
- `reg1_addr_o`, `reg2_addr_o` out REG_AW: regfile read addresses, from `inst_i[25:21]` and `inst_i[20:16]` (combinational).
- `reg1_data_i`, `reg2_data_i` in DATA_W: regfile read data, same cycle.
- `fwd_wreg_i` in NUM_FWD: per-source write enable.
- `fwd_wd_i` in NUM_FWD*REG_AW: per-source destination address.
- `fwd_wdata_i` in NUM_FWD*DATA_W: per-source result.
- `fwd_pend_i` in NUM_FWD: per-source flag; result not yet available (load in EX).
- `flush_i` in 1: discard the held and incoming instruction.
- `out_valid` out 1, `out_ready` in 1: handshake toward EX.
- `aluop_o` out 8, `alusel_o` out 3, `reg1_o`/`reg2_o` out DATA_W, `wd_o` out REG_AW, `wreg_o` out 1, `pc_o` out 32: registered micro-op.
- `instvalid_o` out 1: 1 means legal instruction, 0 means reserved instruction.
- `stall_cnt_o` out STALL_CNT_W: saturating count of hazard-stall cycles.

## Operation
**Decode set**
- SPECIAL with `inst_i[10:6]`=0: OR, AND, XOR, NOR, SLLV, SRLV, SRAV, SYNC.
- Opcodes ORI, ANDI, XORI, LUI, PREF.
- `inst_i[31:21]`=0: SLL, SRL, SRA.
- SRAV and SRA: `alusel`=SHIFT.
- SYNC and PREF: NOP with `wreg`=0, `instvalid`=1.
- Any other encoding: NOP, `wreg`=0, `instvalid_o`=0, still passed to EX.

**Operands**
- I-type logic ops: `imm` = zero-extend(`inst[15:0]`) to DATA_W, with `wd`=rt.
- LUI: `imm` = `{inst[15:0],16'h0}` zero-extended to DATA_W, with `rs` forced to read 0.
- Shift-immediate ops: `reg1` = zero-extend(`inst[10:6]`) and `reg2` = rt.
- A port with read disabled takes `imm`.
- Register 0 always yields 0 and is never forwarded.

**Forwarding**, per enabled read port
- Lowest index `i` with `fwd_wreg_i[i]` set and `fwd_wd_i[i]`==addr wins.
- If that winner has `fwd_pend_i[i]` set, the port is a hazard.
- Otherwise `fwd_wdata_i[i]` is used.
- With no match, regfile data is used.

**Handshake and stall**
- `hazard` = either enabled port is in hazard.
- `in_ready` = `!hazard && !flush_i && (!out_valid || out_ready)`.
- Accept (`in_valid && in_ready`): the output register loads the decoded op and `out_valid`=1.
- Output consumed and nothing accepted: `out_valid`=0 (bubble). The payload is held, not cleared.
- `stall_cnt_o` increments each cycle `in_valid && hazard`, saturating at all-ones.

**Flush**
- Sets `out_valid`=0 on the next edge and blocks acceptance in that cycle.
- Flush beats accept and hazard.

## Timing
- Latency is one cycle from accept to `out_valid`. Throughput is 1 op/cycle when there is no hazard and `out_ready` is high.
- Output payload is stable while `out_valid && !out_ready`.
- Operands are sampled on the accepting edge. Forwarding data that changes afterward does not affect a held op.
- Load-use: with `fwd_pend_i` high for one cycle, `in_ready`=0 for exactly that cycle. The op is accepted the next cycle using the forwarded data.
- Reset values:
  - `out_valid`=0, `aluop_o`=0 (NOP), `alusel_o`=0, `wd_o`=0, `wreg_o`=0.
  - `reg1_o`=`reg2_o`=0, `pc_o`=0, `instvalid_o`=1, `stall_cnt_o`=0.
- Reset mid-stall drops the held op without it being delivered.

## Structure
- Shared package holds:
  - opcode and funct constants;
  - `aluop`/`alusel` codes;
  - `NOPRegAddr`, `ZeroWord`, `RstEnable`=0, `WriteEnable`/`ReadEnable`.
- Natural sub-module: `id_decode`, purely combinational. It maps `inst_i` to aluop, alusel, read enables, wd, wreg, imm and instvalid.
- The top level holds forwarding muxes, hazard logic, the output register and the counter.

## Test plan
- `ori $1,$0,0x1234`, `out_ready`=1 → next cycle `out_valid`=1, `aluop`=OR, `reg1_o`=0, `reg2_o`=0x1234, `wd_o`=1, `wreg_o`=1.
- `or $3,$1,$2` with `fwd[0]`={wreg=1, wd=1, data=0xA} and `fwd[1]`={wreg=1, wd=1, data=0xB} → `reg1_o`=0xA. With only `fwd[1]` matching → 0xB.
- `fwd[0]` match on $1 with `fwd_pend_i[0]`=1 for one cycle → `in_ready`=0 for one cycle, `stall_cnt_o`=1, then accepted with forwarded value.
- `out_ready`=0 for 3 cycles after accept → `out_valid` and payload constant, `in_ready`=0. Then `out_ready`=1 → next op accepted that edge.
- Inst 0xFC000000 → `instvalid_o`=0, `wreg_o`=0, `aluop_o`=NOP. `sra $2,$3,4` → `alusel`=SHIFT, `reg1_o`=4.
- `flush_i` with `out_valid`=1 → next cycle `out_valid`=0. Async `rst` low mid-stall → all outputs at reset values immediately.

Source files
------------

// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants, micro-op codes and the decoder result type for
// the instruction-decode stage.
package id_stage_fwd_pkg;

    // Control polarities and fixed values
    localparam logic        RstEnable    = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        ReadEnable   = 1'b1;
    localparam logic        ReadDisable  = 1'b0;
    localparam logic        InstValid    = 1'b1;
    localparam logic        InstInvalid  = 1'b0;
    localparam logic [4:0]  NOPRegAddr   = 5'd0;
    localparam logic [31:0] ZeroWord     = 32'h0;

    // Primary opcodes
    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;
    localparam logic [5:0] EXE_PREF    = 6'b110011;

    // SPECIAL funct codes
    localparam logic [5:0] EXE_AND  = 6'b100100;
    localparam logic [5:0] EXE_OR   = 6'b100101;
    localparam logic [5:0] EXE_XOR  = 6'b100110;
    localparam logic [5:0] EXE_NOR  = 6'b100111;
    localparam logic [5:0] EXE_SLL  = 6'b000000;
    localparam logic [5:0] EXE_SRL  = 6'b000010;
    localparam logic [5:0] EXE_SRA  = 6'b000011;
    localparam logic [5:0] EXE_SLLV = 6'b000100;
    localparam logic [5:0] EXE_SRLV = 6'b000110;
    localparam logic [5:0] EXE_SRAV = 6'b000111;
    localparam logic [5:0] EXE_SYNC = 6'b001111;

    // Micro-op codes handed to EX
    localparam logic [7:0] EXE_NOP_OP = 8'h00;
    localparam logic [7:0] EXE_AND_OP = 8'h24;
    localparam logic [7:0] EXE_OR_OP  = 8'h25;
    localparam logic [7:0] EXE_XOR_OP = 8'h26;
    localparam logic [7:0] EXE_NOR_OP = 8'h27;
    localparam logic [7:0] EXE_SLL_OP = 8'h7C;
    localparam logic [7:0] EXE_SRL_OP = 8'h02;
    localparam logic [7:0] EXE_SRA_OP = 8'h03;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    // Decoder result; rs_zero makes port 1 read a hard zero (LUI)
    typedef struct packed {
        logic [7:0] aluop;
        logic [2:0] alusel;
        logic       read1;
        logic       read2;
        logic       rs_zero;
        logic [4:0] wd;
        logic       wreg;
        logic       instvalid;
    } dec_t;

    // Register and immediate shift/logic functs share one micro-op each
    function automatic logic [7:0] funct_aluop(input logic [5:0] funct);
        case (funct)
            EXE_AND:            return EXE_AND_OP;
            EXE_OR:             return EXE_OR_OP;
            EXE_XOR:            return EXE_XOR_OP;
            EXE_NOR:            return EXE_NOR_OP;
            EXE_SLL, EXE_SLLV:  return EXE_SLL_OP;
            EXE_SRL, EXE_SRLV:  return EXE_SRL_OP;
            EXE_SRA, EXE_SRAV:  return EXE_SRA_OP;
            default:            return EXE_NOP_OP;
        endcase
    endfunction

endpackage

// File: rtl/id_decode.sv
// Purely combinational instruction decoder: instruction word to micro-op
// fields, read enables, destination and immediate.
module id_decode
    import id_stage_fwd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       inst,
    output dec_t              dec,
    output logic [DATA_W-1:0] imm
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       rtype;

    assign op    = inst[31:26];
    assign funct = inst[5:0];

    // Decode the instruction; anything unrecognised becomes an invalid NOP
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        dec.aluop     = EXE_NOP_OP;
        dec.alusel    = EXE_RES_NOP;
        dec.read1     = ReadDisable;
        dec.read2     = ReadDisable;
        dec.rs_zero   = 1'b0;
        dec.wd        = inst[15:11];
        dec.wreg      = WriteDisable;
        dec.instvalid = InstInvalid;
        imm           = '0;
        rtype         = 1'b0;

        if (inst[31:21] == 11'd0 &&
            (funct == EXE_SLL || funct == EXE_SRL || funct == EXE_SRA)) begin
            // Shift by immediate: sa arrives on port 1 through imm
            dec.aluop     = funct_aluop(funct);
            dec.alusel    = EXE_RES_SHIFT;
            dec.read2     = ReadEnable;
            dec.wreg      = WriteEnable;
            dec.instvalid = InstValid;
            imm           = DATA_W'(inst[10:6]);
        end else if (op == EXE_SPECIAL && inst[10:6] == 5'd0) begin
            case (funct)
                EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
                    dec.alusel = EXE_RES_LOGIC;
                    rtype      = 1'b1;
                end
                EXE_SLLV, EXE_SRLV, EXE_SRAV: begin
                    dec.alusel = EXE_RES_SHIFT;
                    rtype      = 1'b1;
                end
                EXE_SYNC: dec.instvalid = InstValid;
                default:  ;
            endcase
            if (rtype) begin
                dec.aluop     = funct_aluop(funct);
                dec.read1     = ReadEnable;
                dec.read2     = ReadEnable;
                dec.wreg      = WriteEnable;
                dec.instvalid = InstValid;
            end
        end else begin
            case (op)
                EXE_ORI, EXE_ANDI, EXE_XORI: begin
                    dec.aluop     = (op == EXE_ORI)  ? EXE_OR_OP :
                                    (op == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
                    dec.alusel    = EXE_RES_LOGIC;
                    dec.read1     = ReadEnable;
                    dec.wd        = inst[20:16];
                    dec.wreg      = WriteEnable;
                    dec.instvalid = InstValid;
                    imm           = DATA_W'(inst[15:0]);
                end
                EXE_LUI: begin
                    dec.aluop     = EXE_OR_OP;
                    dec.alusel    = EXE_RES_LOGIC;
                    dec.rs_zero   = 1'b1;
                    dec.wd        = inst[20:16];
                    dec.wreg      = WriteEnable;
                    dec.instvalid = InstValid;
                    imm           = DATA_W'({inst[15:0], 16'h0});
                end
                EXE_PREF: dec.instvalid = InstValid;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: regfile read, N-source forwarding with load-use interlock,
// registered micro-op toward EX with valid/ready handshake and flush.
module id_stage_fwd
    import id_stage_fwd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int NUM_FWD     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    output logic                      reg1_read_o,
    output logic                      reg2_read_o,
    output logic [REG_AW-1:0]         reg1_addr_o,
    output logic [REG_AW-1:0]         reg2_addr_o,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         reg2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_pend_i,
    input  logic                      flush_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                aluop_o,
    output logic [2:0]                alusel_o,
    output logic [DATA_W-1:0]         reg1_o,
    output logic [DATA_W-1:0]         reg2_o,
    output logic [REG_AW-1:0]         wd_o,
    output logic                      wreg_o,
    output logic [31:0]               pc_o,
    output logic                      instvalid_o,
    output logic [STALL_CNT_W-1:0]    stall_cnt_o
);

    dec_t              dec;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              haz1;
    logic              haz2;
    logic              hazard;
    logic              accept;

    id_decode #(.DATA_W(DATA_W)) u_decode (
        .inst (inst_i),
        .dec  (dec),
        .imm  (imm)
    );

    assign reg1_read_o = dec.read1;
    assign reg2_read_o = dec.read2;
    assign reg1_addr_o = REG_AW'(inst_i[25:21]);
    assign reg2_addr_o = REG_AW'(inst_i[20:16]);

    // Returns {hazard, operand}; descending scan lets the youngest match win
    function automatic logic [DATA_W:0] resolve(
        input logic                      rd_en,
        input logic [REG_AW-1:0]         addr,
        input logic [DATA_W-1:0]         rf_data,
        input logic [DATA_W-1:0]         alt,
        input logic [NUM_FWD-1:0]        wreg,
        input logic [NUM_FWD*REG_AW-1:0] wd,
        input logic [NUM_FWD*DATA_W-1:0] wdata,
        input logic [NUM_FWD-1:0]        pend
    );
        logic [DATA_W-1:0] v;
        logic              h;
        v = alt;
        h = 1'b0;
        if (rd_en) begin
            v = rf_data;
            if (addr == '0) begin
                v = '0;
            end else begin
                for (int i = NUM_FWD - 1; i >= 0; i--) begin
                    if (wreg[i] && wd[i*REG_AW +: REG_AW] == addr) begin
                        v = wdata[i*DATA_W +: DATA_W];
                        h = pend[i];
                    end
                end
            end
        end
        return {h, v};
    endfunction

    assign {haz1, op1} = resolve(dec.read1, reg1_addr_o, reg1_data_i,
                                 dec.rs_zero ? '0 : imm,
                                 fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pend_i);
    assign {haz2, op2} = resolve(dec.read2, reg2_addr_o, reg2_data_i, imm,
                                 fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pend_i);

    assign hazard   = haz1 | haz2;
    assign in_ready = !hazard && !flush_i && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ID/EX register: load on accept, bubble on consume or flush, hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            out_valid   <= 1'b0;
            aluop_o     <= EXE_NOP_OP;
            alusel_o    <= EXE_RES_NOP;
            reg1_o      <= '0;
            reg2_o      <= '0;
            wd_o        <= REG_AW'(NOPRegAddr);
            wreg_o      <= WriteDisable;
            pc_o        <= ZeroWord;
            instvalid_o <= InstValid;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (flush_i)
                out_valid <= 1'b0;
            else if (accept)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (accept) begin
                aluop_o     <= dec.aluop;
                alusel_o    <= dec.alusel;
                reg1_o      <= op1;
                reg2_o      <= op2;
                wd_o        <= REG_AW'(dec.wd);
                wreg_o      <= dec.wreg;
                pc_o        <= pc_i;
                instvalid_o <= dec.instvalid;
            end
        end
    end

    // Saturating count of cycles a presented instruction is held by a hazard
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable)
            stall_cnt_o <= '0;
        else if (in_valid && hazard && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Scoreboard bench for id_stage_fwd: stimulus pushes expected micro-ops,
// a negedge monitor pops and compares whenever EX takes one.
module tb_id_stage_fwd;

    localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25,
                           OP_XOR = 8'h26, OP_SRA = 8'h03;
    localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2;
    localparam logic [31:0] RF1 = 32'h1111_1111, RF2 = 32'h2222_2222;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] pc;
        logic        instvalid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] pc_i, inst_i;
    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic [1:0]  fwd_wreg_i, fwd_pend_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic        flush_i, out_valid, out_ready;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o, pc_o;
    logic [4:0]  wd_o;
    logic        wreg_o, instvalid_o;
    logic [15:0] stall_cnt_o;

    int   checks = 0;
    int   failures = 0;
    int   last_wait;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_stage_fwd dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
        .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
        .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .instvalid_o(instvalid_o),
        .stall_cnt_o(stall_cnt_o)
    );

    function automatic exp_t mk(logic [7:0] a, logic [2:0] s, logic [31:0] r1,
                                logic [31:0] r2, logic [4:0] wd, logic wr,
                                logic [31:0] pc, logic iv);
        mk = {a, s, r1, r2, wd, wr, pc, iv};
    endfunction

    function automatic exp_t dut_payload();
        return {aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, instvalid_o};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_payload"}, dut_payload(), mk(OP_NOP, SEL_NOP, 0, 0, 0, 0, 0, 1));
        check({tag, "_stall_cnt"}, stall_cnt_o, 16'd0);
    endtask

    task automatic set_fwd(input int idx, input logic wr, input logic [4:0] wd,
                           input logic [31:0] d, input logic p);
        fwd_wreg_i[idx]         = wr;
        fwd_wd_i[idx*5 +: 5]    = wd;
        fwd_wdata_i[idx*32 +: 32] = d;
        fwd_pend_i[idx]         = p;
    endtask

    task automatic clear_fwd();
        fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_pend_i = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Present one instruction until accepted; push its expected micro-op on accept
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        pc_i = pc; inst_i = inst; in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                in_valid  = 1'b0;
                last_wait = k;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL send_timeout pc=%0h actual=no_accept required=accept", pc);
        in_valid = 1'b0;
    endtask

    // Monitor: every transfer to EX must match the oldest expected micro-op
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output actual=%0h required=none", dut_payload());
            end else begin
                check("out_payload", dut_payload(), sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; pc_i = '0; inst_i = '0; flush_i = 1'b0;
        out_ready = 1'b1; reg1_data_i = RF1; reg2_data_i = RF2;
        clear_fwd();
        #2 rst = 1'b0;
        #10;
        check_reset("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic decode and forwarding priority, back to back
        send(32'h3401_1234, 32'h100, mk(OP_OR, SEL_LOGIC, 0, 32'h1234, 1, 1, 32'h100, 1));
        set_fwd(0, 1, 1, 32'hA, 0); set_fwd(1, 1, 1, 32'hB, 0);
        send(32'h0022_1825, 32'h104, mk(OP_OR, SEL_LOGIC, 32'hA, RF2, 3, 1, 32'h104, 1));
        check("throughput", last_wait, 0);
        set_fwd(0, 0, 1, 32'hA, 0);
        send(32'h0022_1825, 32'h108, mk(OP_OR, SEL_LOGIC, 32'hB, RF2, 3, 1, 32'h108, 1));
        set_fwd(0, 1, 1, 32'hA, 0); set_fwd(1, 1, 2, 32'hC, 0);
        send(32'h0022_1825, 32'h10C, mk(OP_OR, SEL_LOGIC, 32'hA, 32'hC, 3, 1, 32'h10C, 1));
        clear_fwd();
        send(32'h0003_1103, 32'h110, mk(OP_SRA, SEL_SHIFT, 32'd4, RF2, 2, 1, 32'h110, 1));
        send(32'hFC00_0000, 32'h114, mk(OP_NOP, SEL_NOP, 0, 0, 0, 0, 32'h114, 0));
        send(32'h3C06_ABCD, 32'h118, mk(OP_OR, SEL_LOGIC, 0, 32'hABCD_0000, 6, 1, 32'h118, 1));
        send(32'h0022_3807, 32'h11C, mk(OP_SRA, SEL_SHIFT, RF1, RF2, 7, 1, 32'h11C, 1));
        send(32'h0000_000F, 32'h120, mk(OP_NOP, SEL_NOP, 0, 0, 0, 0, 32'h120, 1));
        send(32'hCC00_0000, 32'h124, mk(OP_NOP, SEL_NOP, 0, 0, 0, 0, 32'h124, 1));

        // Load-use: pending result stalls exactly one cycle, then forwards
        set_fwd(0, 1, 1, 32'h55, 1);
        inst_i = 32'h0022_1825; pc_i = 32'h130; in_valid = 1'b1;
        @(negedge clk);
        check("loaduse_stall_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        fwd_pend_i[0] = 1'b0;
        @(negedge clk);
        check("loaduse_ready_after", in_ready, 1'b1);
        check("stall_cnt_one", stall_cnt_o, 16'd1);
        if (in_ready) sb.push_back(mk(OP_OR, SEL_LOGIC, 32'h55, RF2, 3, 1, 32'h130, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_fwd();

        // Back-pressure: held payload stable for 3 cycles despite new forwarding data
        idle(1);
        out_ready = 1'b0;
        send(32'h3024_FF00, 32'h140, mk(OP_AND, SEL_LOGIC, RF1, 32'hFF00, 4, 1, 32'h140, 1));
        inst_i = 32'h3805_00FF; pc_i = 32'h144; in_valid = 1'b1;
        set_fwd(0, 1, 1, 32'h99, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_payload", {aluop_o, reg1_o, reg2_o, pc_o},
                  {OP_AND, RF1, 32'h0000_FF00, 32'h140});
            check("hold_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1'b1);
        if (in_ready) sb.push_back(mk(OP_XOR, SEL_LOGIC, 0, 32'hFF, 5, 1, 32'h144, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_fwd();

        // Flush drops the held op and blocks the incoming one
        idle(1);
        out_ready = 1'b0;
        send(32'h3401_1234, 32'h150, mk(OP_OR, SEL_LOGIC, 0, 32'h1234, 1, 1, 32'h150, 1));
        inst_i = 32'h0022_1825; pc_i = 32'h154; in_valid = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        idle(1);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        // Asynchronous reset while an op is held and the next one is stalled
        out_ready = 1'b0;
        send(32'h3C06_ABCD, 32'h160, mk(OP_OR, SEL_LOGIC, 0, 32'hABCD_0000, 6, 1, 32'h160, 1));
        set_fwd(0, 1, 1, 32'h77, 1);
        inst_i = 32'h0022_1825; pc_i = 32'h164; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_cnt_two", stall_cnt_o, 16'd2);
        #2 rst = 1'b0;
        #1;
        check_reset("async_reset");
        sb.delete();
        in_valid = 1'b0; clear_fwd(); out_ready = 1'b1;
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_no_delivery", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
